// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: state codes and
// the pointer-wrap and rotating-priority helpers.
package mux_sched_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  localparam int MAX_DEPTH = 32;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;

  function automatic int next_ptr(input int sel, input int depth);
    return (sel >= depth - 1) ? 0 : sel + 1;
  endfunction

  // First requester at or after ptr, wrapping at depth-1 back to 0.
  function automatic pick_t rr_pick(input logic [MAX_DEPTH-1:0] req,
                                    input int ptr, input int depth);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (k < depth) begin
        j = ptr + k;
        if (j >= depth) j = j - depth;
        if (!res.found && req[j[4:0]]) begin
          res.found = 1'b1;
          res.idx   = 6'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_sched_mux.sv
// Parameterized N:1 one-bit mux; select values at or above depth give 0.
module mux_rr_sched_mux #(
  parameter int width = 2,
  parameter int depth = 4
) (
  input  logic [depth-1:0] in,
  input  logic [width-1:0] sel,
  output logic             out
);

  always_comb begin
    out = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (int'(sel) == i) out = in[i];
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one N:1 mux between depth requesters,
// forwarding up to burst beats per grant over a valid/ready output.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int width = 2,
  parameter int depth = 4,
  parameter int burst = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [depth-1:0] req,
  input  logic [depth-1:0] in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out,
  output logic [width-1:0] sel,
  output logic [depth-1:0] gnt,
  output logic             last,
  output logic             busy
);

  localparam int CW = (burst > 1) ? $clog2(burst) : 1;

  generate
    if (depth > 2**width || depth < 2 || burst < 1) begin : g_param_err
      $error("mux_rr_sched: illegal parameters width=%0d depth=%0d burst=%0d",
             width, depth, burst);
    end
  endgenerate

  logic             state_q, state_d;
  logic [width-1:0] sel_q, sel_d;
  logic [width-1:0] ptr_q, ptr_d;
  logic [depth-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             reqAtSel;
  logic             muxOut;
  pick_t            pick;

  always_comb begin
    reqAtSel = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (int'(sel_q) == i) reqAtSel = req[i];
    end
  end

  mux_rr_sched_mux #(width, depth) u_mux (
    .in  (in),
    .sel (sel_q),
    .out (muxOut)
  );

  // A beat in flight during reset is suppressed so nothing transfers.
  assign busy      = (state_q == GRANT);
  assign out_valid = busy && reqAtSel && !rst;
  assign out       = out_valid & muxOut;
  assign last      = out_valid && (cnt_q == CW'(burst - 1));
  assign sel       = sel_q;
  assign gnt       = gnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(MAX_DEPTH'(req), int'(ptr_q), depth);
    if (state_q == IDLE) begin
      if (pick.found && (pick.idx < 6'(depth))) begin
        state_d = GRANT;
        sel_d   = width'(pick.idx);
        gnt_d   = depth'(1) << pick.idx;
        cnt_d   = '0;
      end
    end else if (!out_valid || (out_ready && last)) begin
      // Withdrawal or final burst beat: hand the pointer to the next requester.
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = width'(next_ptr(int'(sel_q), depth));
    end else if (out_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
